// File: rtl/cpu_out_buffer.sv
// Output buffer behind the CPU: captures one word per rising edge of outFlag
// into a show-ahead FIFO and presents it on a valid/ready stream.
module cpu_out_buffer #(
    parameter int WIDTH        = 36,
    parameter int DEPTH        = 16,
    parameter int ADDRESSWIDTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    startIO,
    input  logic                    outFlag,
    input  logic [WIDTH-1:0]        out,
    input  logic                    clear,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic [WIDTH-1:0]        m_data,
    output logic [ADDRESSWIDTH:0]   count,
    output logic                    overflow
);

    logic [WIDTH-1:0]        mem [DEPTH];
    logic                    flag_q;
    logic [ADDRESSWIDTH-1:0] wr_ptr;
    logic [ADDRESSWIDTH-1:0] rd_ptr;
    logic [ADDRESSWIDTH:0]   cnt;
    logic                    ovf;
    logic                    cap;
    logic                    pop;
    logic                    push;
    logic                    full;

    assign full = (cnt == (ADDRESSWIDTH+1)'(DEPTH));
    assign cap  = outFlag & ~flag_q & startIO;
    assign pop  = m_valid & m_ready;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push = cap & (~full | pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flag_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            flag_q <= outFlag;
            if (clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                ovf    <= 1'b0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    cnt <= cnt + 1'b1;
                else if (pop && !push)
                    cnt <= cnt - 1'b1;
                if (cap && full && !pop)
                    ovf <= 1'b1;
            end
        end
    end

    // Storage is not reset; pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push && !clear)
            mem[wr_ptr] <= out;
    end

    assign m_valid  = (cnt != '0);
    assign m_data   = m_valid ? mem[rd_ptr] : '0;
    assign count    = cnt;
    assign overflow = ovf;

endmodule

// File: tb/tb_cpu_out_buffer.sv
// Directed self-checking bench for cpu_out_buffer.
module tb_cpu_out_buffer;

    logic        clock = 1'b0;
    logic        reset;
    logic        startIO;
    logic        outFlag;
    logic [35:0] out;
    logic        clear;
    logic        m_valid;
    logic        m_ready;
    logic [35:0] m_data;
    logic [4:0]  count;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    cpu_out_buffer #(.WIDTH(36), .DEPTH(16), .ADDRESSWIDTH(4)) dut (
        .clock(clock), .reset(reset), .startIO(startIO), .outFlag(outFlag),
        .out(out), .clear(clear), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .count(count), .overflow(overflow)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic capture(input logic [35:0] val);
        out = val;
        outFlag = 1'b1;
        step();
        outFlag = 1'b0;
        step();
    endtask

    initial begin
        reset = 1'b1; startIO = 1'b0; outFlag = 1'b0; out = '0;
        clear = 1'b0; m_ready = 1'b0;
        step(); step();
        chk("rst_valid", m_valid, 0);
        chk("rst_count", count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_data", m_data, 0);
        reset = 1'b0;
        step();

        // single word, one-cycle latency
        startIO = 1'b1;
        outFlag = 1'b1; out = 36'h0_0000_00AB;
        step();
        chk("single_valid", m_valid, 1);
        chk("single_data", m_data, 36'hAB);
        chk("single_count", count, 1);
        outFlag = 1'b0; m_ready = 1'b1;
        step();
        chk("single_pop_valid", m_valid, 0);
        chk("single_pop_data", m_data, 0);
        chk("single_pop_count", count, 0);
        m_ready = 1'b0;

        // held flag captures once
        outFlag = 1'b1; out = 36'h123;
        repeat (5) step();
        outFlag = 1'b0;
        step();
        chk("held_count", count, 1);
        chk("held_data", m_data, 36'h123);
        outFlag = 1'b1; out = 36'h456;
        step();
        chk("held_count2", count, 2);
        chk("held_head", m_data, 36'h123);
        outFlag = 1'b0; m_ready = 1'b1;
        step();
        chk("held_second", m_data, 36'h456);
        step();
        chk("held_empty", count, 0);
        m_ready = 1'b0;

        // fill, overflow, drain, wrap
        for (int i = 1; i <= 16; i++) capture(36'(i));
        chk("fill_count", count, 16);
        chk("fill_ovf", overflow, 0);
        capture(36'd17);
        chk("ovf_count", count, 16);
        chk("ovf_set", overflow, 1);
        m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            chk("drain_order", m_data, 64'(i));
            step();
        end
        chk("drain_valid", m_valid, 0);
        chk("drain_count", count, 0);
        m_ready = 1'b0;
        capture(36'd20); capture(36'd21); capture(36'd22);
        chk("wrap_count", count, 3);
        m_ready = 1'b1;
        for (int i = 20; i <= 22; i++) begin
            chk("wrap_order", m_data, 64'(i));
            step();
        end
        chk("wrap_empty", m_valid, 0);
        m_ready = 1'b0;

        // full with simultaneous pop
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_ovf", overflow, 0);
        for (int i = 0; i < 16; i++) capture(36'(100 + i));
        chk("full2_count", count, 16);
        out = 36'd99; outFlag = 1'b1; m_ready = 1'b1;
        step();
        chk("simul_count", count, 16);
        chk("simul_ovf", overflow, 0);
        outFlag = 1'b0;
        for (int i = 1; i < 16; i++) begin
            chk("simul_order", m_data, 64'(100 + i));
            step();
        end
        chk("simul_last", m_data, 99);
        step();
        chk("simul_empty", count, 0);
        m_ready = 1'b0;

        // startIO gating
        startIO = 1'b0;
        capture(36'd5); capture(36'd6); capture(36'd7);
        chk("gate_count", count, 0);
        startIO = 1'b1;

        // clear beats a concurrent capture and overflow
        for (int i = 0; i < 17; i++) capture(36'(300 + i));
        chk("pre_clr_ovf", overflow, 1);
        m_ready = 1'b1;
        repeat (11) step();
        m_ready = 1'b0;
        chk("pre_clr_count", count, 5);
        clear = 1'b1; outFlag = 1'b1; out = 36'd77;
        step();
        clear = 1'b0;
        chk("clr_count", count, 0);
        chk("clr_ovf2", overflow, 0);
        chk("clr_valid", m_valid, 0);
        step();
        chk("clr_no_recap", count, 0);
        outFlag = 1'b0;
        step();

        // asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) capture(36'(200 + i));
        chk("pre_rst_count", count, 7);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", m_valid, 0);
        chk("arst_count", count, 0);
        chk("arst_data", m_data, 0);
        outFlag = 1'b1; out = 36'h3AB;
        step();
        reset = 1'b0;
        step();
        chk("post_rst_count", count, 1);
        chk("post_rst_data", m_data, 36'h3AB);
        repeat (3) step();
        chk("post_rst_once", count, 1);
        outFlag = 1'b0; m_ready = 1'b1;
        step();
        chk("post_rst_pop", count, 0);
        m_ready = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
